// File: rtl/riscv_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// riscv_fetch_unit_if
// Bundles every handshake of the fetch stage:
//   imem_req_*  : fetch requests to instruction memory (valid/ready)
//   imem_rsp_*  : in-order instruction words returned by memory
//   redirect_*  : PC change requested by the core
//   inst_*      : PC-tagged instruction words delivered to the core (valid/ready)
// master = the fetch unit, slave = the surrounding memory + core.
// -----------------------------------------------------------------------------
interface riscv_fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/riscv_fetch_unit.sv
// -----------------------------------------------------------------------------
// riscv_fetch_unit
// Instruction fetch stage. Issues sequential word-aligned fetch addresses to
// instruction memory while credits remain (FIFO occupancy + in-flight requests
// < DEPTH), buffers in-order responses tagged with their PC in a DEPTH-entry
// FIFO, and hands them to the core. A redirect clears the FIFO, restarts
// fetch at the (word-aligned) target and squashes responses still in flight.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : riscv_fetch_unit_if.master (imem request/response, redirect,
//          instruction delivery). Interface ADDR_W must match ADDR_W here.
// -----------------------------------------------------------------------------
module riscv_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  riscv_fetch_unit_if.master bus
);
  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W:0]    LIMIT    = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(32'd4);

  // Architectural state
  logic [ADDR_W-1:0] fetch_pc_r, rsp_pc_r;
  logic [CNT_W-1:0]  count_r, outstanding_r, squash_r;
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [31:0]       mem_data_r [DEPTH];
  logic [ADDR_W-1:0] mem_pc_r   [DEPTH];

  // Next-state values
  logic [ADDR_W-1:0] fetch_pc_s, rsp_pc_s;
  logic [CNT_W-1:0]  count_s, outstanding_s, squash_s;
  logic [PTR_W-1:0]  wr_ptr_s, rd_ptr_s;

  logic              req_fire_s, push_s, pop_s, credit_s, head_valid_s;
  logic [ADDR_W-1:0] redirect_pc_s;
  logic              unused_s;

  // Low address bits of the redirect target are ignored by design.
  assign unused_s      = ^bus.redirect_pc[1:0];
  assign redirect_pc_s = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

  // Squashed requests still hold credits until their responses return.
  assign credit_s   = ({1'b0, count_r} + {1'b0, outstanding_r}) < LIMIT;
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && credit_s;
  assign bus.imem_req_addr  = fetch_pc_r;
  assign req_fire_s = bus.imem_req_valid && bus.imem_req_ready;

  // Only live responses enter the FIFO; credits guarantee it is never full here.
  assign push_s = bus.imem_rsp_valid && (squash_r == ZERO_CNT) && !bus.redirect_valid;

  // The empty FIFO shows fixed idle values so outputs are defined right after reset.
  assign head_valid_s   = (count_r != ZERO_CNT);
  assign bus.inst_valid = head_valid_s && !bus.redirect_valid;
  assign bus.inst_data  = head_valid_s ? mem_data_r[rd_ptr_r] : 32'h0000_0000;
  assign bus.inst_pc    = head_valid_s ? mem_pc_r[rd_ptr_r] : RESET_PC;
  assign pop_s          = bus.inst_valid && bus.inst_ready;

  // Next-state logic: redirect overrides request, response and pop activity.
  always_comb begin
    fetch_pc_s    = fetch_pc_r;
    rsp_pc_s      = rsp_pc_r;
    count_s       = count_r;
    outstanding_s = outstanding_r;
    squash_s      = squash_r;
    wr_ptr_s      = wr_ptr_r;
    rd_ptr_s      = rd_ptr_r;
    if (bus.redirect_valid) begin
      fetch_pc_s    = redirect_pc_s;
      rsp_pc_s      = redirect_pc_s;
      count_s       = ZERO_CNT;
      wr_ptr_s      = {PTR_W{1'b0}};
      rd_ptr_s      = {PTR_W{1'b0}};
      // A response arriving this very cycle retires one in-flight request.
      squash_s      = outstanding_r - CNT_W'(bus.imem_rsp_valid);
      outstanding_s = outstanding_r - CNT_W'(bus.imem_rsp_valid);
    end else begin
      if (req_fire_s) begin
        fetch_pc_s = fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_s = fetch_pc_r;
      end
      outstanding_s = outstanding_r + CNT_W'(req_fire_s) - CNT_W'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && (squash_r != ZERO_CNT)) begin
        squash_s = squash_r - CNT_W'(1'b1);
      end else begin
        squash_s = squash_r;
      end
      if (push_s) begin
        rsp_pc_s = rsp_pc_r + PC_STEP;
        wr_ptr_s = wr_ptr_r + PTR_W'(1'b1);
      end else begin
        rsp_pc_s = rsp_pc_r;
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      count_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      count_r       <= ZERO_CNT;
      outstanding_r <= ZERO_CNT;
      squash_r      <= ZERO_CNT;
      wr_ptr_r      <= {PTR_W{1'b0}};
      rd_ptr_r      <= {PTR_W{1'b0}};
    end else begin
      fetch_pc_r    <= fetch_pc_s;
      rsp_pc_r      <= rsp_pc_s;
      count_r       <= count_s;
      outstanding_r <= outstanding_s;
      squash_r      <= squash_s;
      wr_ptr_r      <= wr_ptr_s;
      rd_ptr_r      <= rd_ptr_s;
    end
  end

  // FIFO storage; contents are only observed through an occupied head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_r[wr_ptr_r] <= bus.imem_rsp_data;
      mem_pc_r[wr_ptr_r]   <= rsp_pc_r;
    end
  end
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_riscv_fetch_unit
// Directed bench for riscv_fetch_unit (DEPTH=4, RESET_PC=0). A small in-order
// memory model with programmable latency answers requests with a word derived
// from the address; expected PCs and data are hand-derived per step.
// -----------------------------------------------------------------------------
module tb_riscv_fetch_unit;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;

  riscv_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  riscv_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (4),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat    = 1;
  int fires  = 0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record accepted request, retire consumed response, drive the next one.
  task automatic tick();
    logic        fire;
    logic [31:0] a;
    logic [31:0] dropped;
    int          dd;
    #1;
    fire = bus.imem_req_valid && bus.imem_req_ready;
    a    = bus.imem_req_addr;
    @(posedge clk);
    cyc++;
    #1;
    if (fire) fires++;
    if (bus.imem_rsp_valid && (q_addr.size() > 0)) begin
      dropped = q_addr.pop_front();
      dd      = q_due.pop_front();
    end
    if (fire && !rst) begin
      q_addr.push_back(a);
      q_due.push_back(cyc + lat);
    end
    if ((q_addr.size() > 0) && (q_due[0] <= cyc + 1)) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = word_of(q_addr[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.inst_ready     = 1'b0;
    #2;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("rst_req_addr",  bus.imem_req_addr,       32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid),    32'h0);
    chk("rst_inst_data", bus.inst_data,           32'h0);
    chk("rst_inst_pc",   bus.inst_pc,             32'h0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("first_req_addr",  bus.imem_req_addr,       32'h0);

    // Backpressure from reset: exactly 4 requests, then the stage stalls.
    tick();
    chk("bp_req_addr_e1", bus.imem_req_addr, 32'h4);
    chk("bp_no_bypass",   32'(bus.inst_valid), 32'h0);
    tick(); tick(); tick();
    chk("bp_inst_valid_e4", 32'(bus.inst_valid), 32'h1);
    chk("bp_inst_pc_e4",    bus.inst_pc, 32'h0);
    chk("bp_req_stop_e4",   32'(bus.imem_req_valid), 32'h0);
    for (int k = 5; k <= 10; k++) begin
      tick();
      chk("bp_req_valid", 32'(bus.imem_req_valid), 32'h0);
      chk("bp_hold_pc",   bus.inst_pc, 32'h0);
      chk("bp_hold_data", bus.inst_data, word_of(32'h0));
    end
    chk("bp_req_count", 32'(fires), 32'd4);

    // Drain then stream one instruction per cycle; requests resume at 0x10.
    bus.inst_ready = 1'b1;
    for (int k = 11; k <= 18; k++) begin
      tick();
      chk("st_inst_valid", 32'(bus.inst_valid), 32'h1);
      chk("st_inst_pc",    bus.inst_pc, 32'(4 * (k - 10)));
      chk("st_inst_data",  bus.inst_data, word_of(32'(4 * (k - 10))));
      chk("st_req_valid",  32'(bus.imem_req_valid), 32'h1);
      chk("st_req_addr",   bus.imem_req_addr, 32'(4 * (k - 7)));
    end

    // Redirect to 0x100 with two requests in flight (latency 3).
    lat = 3;
    tick();
    chk("lat3_inst_pc_e19", bus.inst_pc, 32'h24);
    tick();
    chk("lat3_inst_pc_e20", bus.inst_pc, 32'h28);
    chk("lat3_req_addr_e20", bus.imem_req_addr, 32'h34);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    chk("rd1_req_blocked",  32'(bus.imem_req_valid), 32'h0);
    chk("rd1_inst_blocked", 32'(bus.inst_valid), 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("rd1_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("rd1_req_addr",  bus.imem_req_addr, 32'h100);
    chk("rd1_flushed",   32'(bus.inst_valid), 32'h0);
    for (int k = 22; k <= 24; k++) begin
      tick();
      chk("rd1_stale_dropped", 32'(bus.inst_valid), 32'h0);
    end
    tick();
    chk("rd1_inst_valid", 32'(bus.inst_valid), 32'h1);
    chk("rd1_inst_pc",    bus.inst_pc, 32'h100);
    chk("rd1_inst_data",  bus.inst_data, word_of(32'h100));
    chk("rd1_credit_full", 32'(bus.imem_req_valid), 32'h0);
    tick();
    chk("rd1_inst_pc_next", bus.inst_pc, 32'h104);
    chk("rd1_inst_data_next", bus.inst_data, word_of(32'h104));
    chk("rd1_req_resume", 32'(bus.imem_req_valid), 32'h1);
    chk("rd1_req_addr_resume", bus.imem_req_addr, 32'h110);

    // Misaligned redirect coinciding with a response while the core is ready.
    chk("rd2_rsp_present", 32'(bus.imem_rsp_valid), 32'h1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h203;
    #1;
    chk("rd2_no_pop", 32'(bus.inst_valid), 32'h0);
    chk("rd2_no_req", 32'(bus.imem_req_valid), 32'h0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("rd2_req_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("rd2_req_addr",  bus.imem_req_addr, 32'h200);
    for (int k = 28; k <= 30; k++) begin
      tick();
      chk("rd2_stale_dropped", 32'(bus.inst_valid), 32'h0);
    end
    tick();
    chk("rd2_inst_valid", 32'(bus.inst_valid), 32'h1);
    chk("rd2_inst_pc",    bus.inst_pc, 32'h200);
    chk("rd2_inst_data",  bus.inst_data, word_of(32'h200));

    // Fill the FIFO to three entries with the core stalled.
    bus.inst_ready = 1'b0;
    tick();
    chk("fill_hold_pc_e32", bus.inst_pc, 32'h200);
    chk("fill_req_valid_e32", 32'(bus.imem_req_valid), 32'h0);
    tick();
    chk("fill_hold_pc_e33", bus.inst_pc, 32'h200);
    chk("fill_hold_data_e33", bus.inst_data, word_of(32'h200));

    // Asynchronous reset between edges; memory is reset alongside.
    rst = 1'b1;
    q_addr.delete();
    q_due.delete();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    #1;
    chk("arst_req_valid",  32'(bus.imem_req_valid), 32'h0);
    chk("arst_req_addr",   bus.imem_req_addr, 32'h0);
    chk("arst_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("arst_inst_data",  bus.inst_data, 32'h0);
    chk("arst_inst_pc",    bus.inst_pc, 32'h0);
    lat = 1;
    bus.inst_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("arst_restart_valid", 32'(bus.imem_req_valid), 32'h1);
    chk("arst_restart_addr",  bus.imem_req_addr, 32'h0);
    tick();
    tick();
    chk("arst_inst_valid_after", 32'(bus.inst_valid), 32'h1);
    chk("arst_inst_pc_after",    bus.inst_pc, 32'h0);
    chk("arst_inst_data_after",  bus.inst_data, word_of(32'h0));
    tick();
    chk("arst_inst_pc_next", bus.inst_pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/riscv_fetch_unit.md
# riscv_fetch_unit

Instruction fetch stage that sits directly upstream of the RISC-V core. It generates sequential byte addresses from a fetch PC and issues them to instruction memory over a valid/ready request channel. In-order responses are buffered in a DEPTH-entry prefetch FIFO, which presents instruction words tagged with their PC to the core over a valid/ready channel. A redirect from the core (branch, jal, jalr) flushes the buffer and squashes in-flight responses.

## Interface
- ADDR_W, 32, address and PC width
- DEPTH, 4, prefetch FIFO entries and maximum credits (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  ADDR_W  fetch byte address, bits [1:0] always 0
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response word valid; in order, ≥1 cycle after request accept
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  core requests PC change (single-cycle pulse or held)
- redirect_pc  in  ADDR_W  new fetch PC; bits [1:0] ignored (treated as 0)
- inst_valid  out  1  instruction available to core
- inst_data  out  32  instruction word (core's din)
- inst_pc  out  ADDR_W  byte address of inst_data
- inst_ready  in  1  core consumes instruction

## Operation
- State:
  - fetch_pc: next address to request.
  - rsp_pc: PC of the next non-squashed response.
  - count: FIFO occupancy, 0..DEPTH.
  - outstanding: accepted requests without response, 0..DEPTH.
  - squash: responses still to drop, ≤ outstanding.
- Credit rule: imem_req_valid = !redirect_valid && (count + outstanding < DEPTH). imem_req_addr = fetch_pc.
- Request accept (valid && ready): fetch_pc += 4 (wraps modulo 2^ADDR_W), outstanding += 1.
- Response, squash > 0: word discarded; squash −= 1, outstanding −= 1.
- Response, squash == 0: {rsp_pc, data} pushed to FIFO; rsp_pc += 4; outstanding −= 1.
- Pop: inst_valid && inst_ready removes the head entry. inst_valid = (count != 0) && !redirect_valid.
- Push and pop in the same cycle: both occur, count is unchanged. The credit rule guarantees a push never finds the FIFO full.
- Redirect (redirect_valid=1), taking priority over all other events that cycle:
  - FIFO cleared (count=0). No pop, no request issued.
  - fetch_pc = rsp_pc = {redirect_pc[ADDR_W-1:2],2'b00}.
  - squash = outstanding − (imem_rsp_valid ? 1 : 0).
  - outstanding = squash.
  - Any same-cycle response is dropped.
- Held redirect: each cycle repeats the redirect actions with the current redirect_pc. The last cycle's value wins.
- Reset (async, any time, including mid-flight):
  - fetch_pc = rsp_pc = RESET_PC; count = outstanding = squash = 0.
  - Memory responses arriving after reset deassertion for pre-reset requests are the memory's responsibility. Integration resets memory with the same rst.

## Timing
- Reset values: imem_req_valid=0 while rst=1. imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=RESET_PC.
- First request: imem_req_valid=1 in the first cycle after rst deasserts, with addr=RESET_PC.
- Back-to-back issue: one request per cycle while credits remain and imem_req_ready=1.
- Response to inst_valid: 1 cycle. A response at edge N gives inst_valid=1 after edge N, when the FIFO was empty. There is no combinational bypass from imem_rsp to inst.
- Redirect to new request: the request for the redirect target is presented in the cycle after the redirect edge, provided credits allow (squashed in-flight requests still consume credits until they return).
- Redirect to first valid instruction: 1 cycle plus memory latency plus 1 cycle.
- Stall: with inst_ready=0, the FIFO fills. imem_req_valid drops once count+outstanding=DEPTH and reasserts the cycle after a pop.
- inst_data and inst_pc hold stable while inst_valid=1 and inst_ready=0.

## Test plan
- Reset then streaming: memory with 1-cycle latency and ready=1, core ready=1. Requests go to 0x0, 0x4, 0x8, … on consecutive cycles. inst_pc sequence 0x0, 0x4, 0x8, … with matching data; one instruction per cycle in steady state.
- Backpressure: inst_ready=0 for 10 cycles with DEPTH=4. Exactly 4 requests are issued, then imem_req_valid=0. Raising inst_ready drains PCs 0x0–0xC in order, and requests resume at 0x10.
- Redirect with in-flight requests: memory latency 3 cycles, redirect to 0x100 while 2 requests are outstanding. Both stale responses are dropped. The first inst_valid shows inst_pc=0x100. No entry with PC below 0x100 appears after the redirect.
- Redirect coinciding with a response and with inst_ready=1: the response is dropped and no pop occurs (inst_valid=0 that cycle). squash equals outstanding−1, and the next delivered PC is the redirect target.
- Misaligned redirect_pc=0x203: the fetch goes to 0x200 and inst_pc=0x200.
- Async reset mid-stream, asserted between clock edges with FIFO count=3: outputs go to reset values immediately. After deassertion, fetch restarts at RESET_PC.
